// File: rtl/prefetch_stage_pkg.sv
// Shared fetch-side constants: buffer/outstanding defaults and OBI word geometry.
// Imported by the prefetch stage and its instruction buffer.
package prefetch_stage_pkg;

  localparam int PF_DEPTH      = 4;
  localparam int PF_MAX_OUTST  = 2;
  localparam int OBI_WORD_BYTES = 4;
  localparam int ILEN          = 32;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prefetch_stage_sync_fifo.sv
// Synchronous FIFO with flush and async active-low reset.
// Head data reads as zero while empty so consumers never see stale entries.
module sync_fifo
  import prefetch_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem[rd_q];

  always_comb begin
    do_push = push_i && (!full_o || pop_i);
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_q] <= data_i;
  end

endmodule

// File: rtl/prefetch_stage.sv
// Instruction prefetch: OBI fetch engine feeding an in-order instruction buffer.
// Redirects flush the buffer and drop every response from the old stream.
module prefetch_stage
  import prefetch_stage_pkg::*;
#(
  parameter int               VADDR      = 39,
  parameter logic [VADDR-1:0] RESET_ADDR = '0,
  parameter int               DEPTH      = PF_DEPTH,
  parameter int               MAX_OUTST  = PF_MAX_OUTST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_i,
  input  logic [VADDR-1:0] redirect_addr_i,
  output logic             imem_req_o,
  output logic [VADDR-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [ILEN-1:0]  instr_o,
  output logic [VADDR-1:0] pc_o
);

  localparam int OW = cnt_width(MAX_OUTST);
  localparam int CW = cnt_width(DEPTH);
  localparam int EW = ILEN + VADDR;

  localparam logic [VADDR-1:0] WMASK = ~VADDR'(OBI_WORD_BYTES - 1);
  localparam logic [VADDR-1:0] HMASK = ~VADDR'(1);
  localparam logic [VADDR-1:0] WSTEP = VADDR'(OBI_WORD_BYTES);

  logic             req_q, req_d;
  logic [VADDR-1:0] fetch_q, fetch_d;
  logic [VADDR-1:0] rsp_pc_q, rsp_pc_d;
  logic             stale_q, stale_d;
  logic [VADDR-1:0] stale_addr_q, stale_addr_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [OW-1:0]    discard_q, discard_d;
  logic [OW-1:0]    live;
  logic [CW-1:0]    cnt_nxt;
  logic             room;

  logic             fire;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic             buf_empty;
  logic             buf_full;
  logic [CW-1:0]    buf_cnt;

  assign fire          = req_q && imem_gnt_i;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = stale_q ? stale_addr_q : fetch_q;
  assign instr_valid_o = !buf_empty;
  assign {instr_o, pc_o} = head;

  assign pop  = !buf_empty && instr_ready_i && !redirect_i;
  assign push = imem_rvalid_i && (discard_q == '0) && !redirect_i
             && (!buf_full || pop);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  ({imem_rdata_i, rsp_pc_q}),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (buf_empty),
    .full_o  (buf_full),
    .count_o (buf_cnt)
  );

  always_comb begin
    outst_d = outst_q;
    unique case ({fire, imem_rvalid_i})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    // After a redirect everything still in flight belongs to the old stream.
    discard_d = discard_q;
    if (redirect_i) begin
      discard_d = outst_d;
    end else begin
      if (imem_rvalid_i && discard_q != '0) discard_d = discard_d - OW'(1);
      if (stale_q && fire)                  discard_d = discard_d + OW'(1);
    end

    stale_d      = stale_q;
    stale_addr_d = stale_addr_q;
    if (redirect_i && req_q && !imem_gnt_i) begin
      stale_d      = 1'b1;
      stale_addr_d = imem_addr_o;
    end else if (fire) begin
      stale_d = 1'b0;
    end

    fetch_d = fetch_q;
    if (redirect_i)            fetch_d = redirect_addr_i & WMASK;
    else if (fire && !stale_q) fetch_d = fetch_q + WSTEP;

    rsp_pc_d = rsp_pc_q;
    if (redirect_i) rsp_pc_d = redirect_addr_i & HMASK;
    else if (push)  rsp_pc_d = (rsp_pc_q & WMASK) + WSTEP;

    cnt_nxt = buf_cnt;
    if (redirect_i) begin
      cnt_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt_nxt = buf_cnt + CW'(1);
        2'b01:   cnt_nxt = buf_cnt - CW'(1);
        default: cnt_nxt = buf_cnt;
      endcase
    end

    // Reserve a buffer slot for every response that will actually land.
    live = outst_d - discard_d;
    room = (int'(outst_d) < MAX_OUTST)
        && (int'(cnt_nxt) + int'(live) < DEPTH);

    req_d = room;
    if (req_q && !imem_gnt_i) req_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q        <= 1'b0;
      fetch_q      <= RESET_ADDR & WMASK;
      rsp_pc_q     <= RESET_ADDR & HMASK;
      stale_q      <= 1'b0;
      stale_addr_q <= RESET_ADDR & WMASK;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      req_q        <= req_d;
      fetch_q      <= fetch_d;
      rsp_pc_q     <= rsp_pc_d;
      stale_q      <= stale_d;
      stale_addr_q <= stale_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

endmodule

// File: tb/tb_prefetch_stage.sv
// Directed bench for prefetch_stage: streaming/backpressure table plus
// hand-written redirect and reset sequences against a 1-cycle OBI memory.
module tb_prefetch_stage;

  localparam int VADDR = 39;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             redirect_i = 1'b0;
  logic [VADDR-1:0] redirect_addr_i = '0;
  logic             imem_req_o;
  logic [VADDR-1:0] imem_addr_o;
  logic             imem_gnt_i = 1'b0;
  logic             imem_rvalid_i = 1'b0;
  logic [31:0]      imem_rdata_i = '0;
  logic             instr_valid_o;
  logic             instr_ready_i = 1'b1;
  logic [31:0]      instr_o;
  logic [VADDR-1:0] pc_o;

  prefetch_stage #(
    .VADDR      (VADDR),
    .RESET_ADDR ('0),
    .DEPTH      (4),
    .MAX_OUTST  (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             ready;
    logic             exp_req;
    logic [VADDR-1:0] exp_addr;
    logic             exp_valid;
    logic [VADDR-1:0] exp_pc;
  } vec_t;

  vec_t             tbl [15];
  logic [VADDR-1:0] q [$];
  int               total = 0;
  int               bad = 0;
  int               gcnt = 0;
  logic             gnt_en = 1'b1;
  logic             rsp_en = 1'b1;

  function automatic logic [31:0] rd(input logic [VADDR-1:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One cycle: wait for the negedge, then drive the memory side for it.
  task automatic cyc();
    @(negedge clk);
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rsp_en && q.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = rd(q.pop_front());
    end
    imem_gnt_i = gnt_en && imem_req_o;
    if (imem_gnt_i) begin
      q.push_back(imem_addr_o);
      gcnt++;
    end
  endtask

  task automatic do_reset();
    rst_ni          = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    imem_gnt_i      = 1'b0;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    instr_ready_i   = 1'b1;
    gnt_en          = 1'b1;
    rsp_en          = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    gcnt   = 0;
    rst_ni = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 39'h00, 1'b0, 39'h0};
    tbl[1]  = '{1'b1, 1'b1, 39'h04, 1'b0, 39'h0};
    tbl[2]  = '{1'b1, 1'b1, 39'h08, 1'b1, 39'h00};
    tbl[3]  = '{1'b1, 1'b1, 39'h0C, 1'b1, 39'h04};
    tbl[4]  = '{1'b1, 1'b1, 39'h10, 1'b1, 39'h08};
    tbl[5]  = '{1'b1, 1'b1, 39'h14, 1'b1, 39'h0C};
    tbl[6]  = '{1'b0, 1'b1, 39'h18, 1'b1, 39'h10};
    tbl[7]  = '{1'b0, 1'b1, 39'h1C, 1'b1, 39'h10};
    tbl[8]  = '{1'b0, 1'b0, 39'h00, 1'b1, 39'h10};
    tbl[9]  = '{1'b0, 1'b0, 39'h00, 1'b1, 39'h10};
    tbl[10] = '{1'b0, 1'b0, 39'h00, 1'b1, 39'h10};
    tbl[11] = '{1'b1, 1'b0, 39'h00, 1'b1, 39'h10};
    tbl[12] = '{1'b0, 1'b1, 39'h20, 1'b1, 39'h14};
    tbl[13] = '{1'b0, 1'b0, 39'h00, 1'b1, 39'h14};
    tbl[14] = '{1'b0, 1'b0, 39'h00, 1'b1, 39'h14};

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(instr_valid_o), 64'(0));
    chk("rst_req", 64'(imem_req_o), 64'(0));
    chk("rst_addr", 64'(imem_addr_o), 64'(0));
    chk("rst_instr", 64'(instr_o), 64'(0));
    chk("rst_pc", 64'(pc_o), 64'(0));

    // Streaming then backpressure, cycle by cycle
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc();
      instr_ready_i = tbl[i].ready;
      chk($sformatf("tbl%0d_valid", i), 64'(instr_valid_o),
          64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_req", i), 64'(imem_req_o), 64'(tbl[i].exp_req));
      if (tbl[i].exp_req)
        chk($sformatf("tbl%0d_addr", i), 64'(imem_addr_o),
            64'(tbl[i].exp_addr));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), 64'(pc_o), 64'(tbl[i].exp_pc));
        chk($sformatf("tbl%0d_instr", i), 64'(instr_o),
            64'(rd(tbl[i].exp_pc)));
      end
    end

    // Backpressure from empty: exactly DEPTH grants, one pop frees one
    do_reset();
    instr_ready_i = 1'b0;
    repeat (12) cyc();
    chk("bp_grants", 64'(gcnt), 64'(4));
    chk("bp_req_low", 64'(imem_req_o), 64'(0));
    chk("bp_head_pc", 64'(pc_o), 64'(0));
    instr_ready_i = 1'b1;
    cyc();
    instr_ready_i = 1'b0;
    repeat (6) cyc();
    chk("bp_grants_after_pop", 64'(gcnt), 64'(5));
    chk("bp_req_low2", 64'(imem_req_o), 64'(0));
    chk("bp_head_pc2", 64'(pc_o), 64'(4));

    // Redirect with two reads in flight
    do_reset();
    rsp_en = 1'b0;
    cyc();
    chk("fl_addr0", 64'(imem_addr_o), 64'(0));
    cyc();
    chk("fl_addr1", 64'(imem_addr_o), 64'(4));
    cyc();
    chk("fl_cap_req", 64'(imem_req_o), 64'(0));
    redirect_i      = 1'b1;
    redirect_addr_i = 39'h100;
    rsp_en          = 1'b1;
    cyc();
    chk("fl_valid_c4", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("fl_req_c5", 64'(imem_req_o), 64'(1));
    chk("fl_addr_c5", 64'(imem_addr_o), 64'(39'h100));
    chk("fl_valid_c5", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("fl_valid_c6", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("fl_valid_c7", 64'(instr_valid_o), 64'(1));
    chk("fl_pc_c7", 64'(pc_o), 64'(39'h100));
    chk("fl_instr_c7", 64'(instr_o), 64'(rd(39'h100)));
    cyc();
    chk("fl_pc_c8", 64'(pc_o), 64'(39'h104));

    // Halfword redirect straight out of reset
    do_reset();
    redirect_i      = 1'b1;
    redirect_addr_i = 39'h202;
    cyc();
    chk("hw_req", 64'(imem_req_o), 64'(1));
    chk("hw_addr", 64'(imem_addr_o), 64'(39'h200));
    cyc();
    chk("hw_valid_c2", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("hw_valid_c3", 64'(instr_valid_o), 64'(1));
    chk("hw_pc0", 64'(pc_o), 64'(39'h202));
    chk("hw_instr0", 64'(instr_o), 64'(rd(39'h200)));
    cyc();
    chk("hw_pc1", 64'(pc_o), 64'(39'h204));
    chk("hw_instr1", 64'(instr_o), 64'(rd(39'h204)));

    // Redirect while the request waits for grant
    do_reset();
    gnt_en = 1'b0;
    cyc();
    chk("pd_req_c1", 64'(imem_req_o), 64'(1));
    chk("pd_addr_c1", 64'(imem_addr_o), 64'(0));
    cyc();
    redirect_i      = 1'b1;
    redirect_addr_i = 39'h40;
    cyc();
    chk("pd_req_c3", 64'(imem_req_o), 64'(1));
    chk("pd_addr_c3", 64'(imem_addr_o), 64'(0));
    gnt_en = 1'b1;
    cyc();
    chk("pd_addr_c4", 64'(imem_addr_o), 64'(0));
    cyc();
    chk("pd_req_c5", 64'(imem_req_o), 64'(1));
    chk("pd_addr_c5", 64'(imem_addr_o), 64'(39'h40));
    chk("pd_valid_c5", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("pd_valid_c6", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("pd_valid_c7", 64'(instr_valid_o), 64'(1));
    chk("pd_pc_c7", 64'(pc_o), 64'(39'h40));
    chk("pd_instr_c7", 64'(instr_o), 64'(rd(39'h40)));

    // Redirect overriding a same-cycle pop and response
    do_reset();
    repeat (4) cyc();
    chk("ov_pc_c4", 64'(pc_o), 64'(4));
    redirect_i      = 1'b1;
    redirect_addr_i = 39'h300;
    cyc();
    chk("ov_valid_c5", 64'(instr_valid_o), 64'(0));
    chk("ov_addr_c5", 64'(imem_addr_o), 64'(39'h300));
    cyc();
    chk("ov_valid_c6", 64'(instr_valid_o), 64'(0));
    cyc();
    chk("ov_pc_c7", 64'(pc_o), 64'(39'h300));

    // Asynchronous reset mid-stream
    do_reset();
    repeat (5) cyc();
    chk("mr_pc_before", 64'(pc_o), 64'(8));
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_valid_async", 64'(instr_valid_o), 64'(0));
    chk("mr_req_async", 64'(imem_req_o), 64'(0));
    do_reset();
    cyc();
    chk("mr_req_after", 64'(imem_req_o), 64'(1));
    chk("mr_addr_after", 64'(imem_addr_o), 64'(0));
    chk("mr_valid_after", 64'(instr_valid_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
